// File: rtl/cpu_run_controller.sv
// Run-control sequencer for the single-cycle CPU: reset hold, run/halt/step,
// breakpoint and halt-instruction stops, and a per-commit clock enable.
module cpu_run_controller #(
   parameter int DIV          = 22,
   parameter int RESET_CYCLES = 4,
   parameter int PC_W         = 32,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   input  logic             halt_instr,
   output logic             cpu_ce,
   output logic             cpu_reset,
   output logic [1:0]       state,
   output logic [1:0]       halt_reason,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int DW = $clog2(DIV);

   localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   localparam logic [1:0] HR_NONE  = 2'd0;
   localparam logic [1:0] HR_REQ   = 2'd1;
   localparam logic [1:0] HR_BP    = 2'd2;
   localparam logic [1:0] HR_INSTR = 2'd3;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } run_state_t;

   run_state_t       cur_st;
   run_state_t       nxt_st;

   logic [RW-1:0]    rst_cnt;
   logic [RW-1:0]    rst_cnt_d;
   logic [DW-1:0]    div_cnt;
   logic [DW-1:0]    div_cnt_d;
   logic             bp_skip;
   logic             bp_skip_d;
   logic             cpu_reset_d;
   logic [1:0]       reason_d;
   logic [CNT_W-1:0] count_d;

   logic             active;
   logic             issue;
   logic             bp_hit;
   logic             rst_done;
   logic             commit;

   assign state    = cur_st;
   assign active   = (cur_st == ST_RUN) || (cur_st == ST_STEP);
   assign issue    = active && (div_cnt == DIV_LAST);
   assign bp_hit   = bp_en && (pc == bp_addr) && !bp_skip;
   assign rst_done = (rst_cnt == RST_LAST);

   // An issue point commits unless any stop condition claims the cycle.
   assign commit = issue && !halt_req && !halt_instr && !bp_hit;
   assign cpu_ce = commit && !cpu_reset;

   // State register; reset drops straight back into the reset hold.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cur_st <= ST_RST;
      end else begin
         cur_st <= nxt_st;
      end
   end

   // Counters, stop reason and the breakpoint resume flag.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         rst_cnt     <= '0;
         div_cnt     <= '0;
         bp_skip     <= 1'b0;
         cpu_reset   <= 1'b1;
         halt_reason <= HR_NONE;
         cycle_count <= '0;
      end else begin
         rst_cnt     <= rst_cnt_d;
         div_cnt     <= div_cnt_d;
         bp_skip     <= bp_skip_d;
         cpu_reset   <= cpu_reset_d;
         halt_reason <= reason_d;
         cycle_count <= count_d;
      end
   end

   // Next-state and next-value decode; stop checks in priority order.
   always_comb begin
      nxt_st      = cur_st;
      rst_cnt_d   = rst_cnt;
      div_cnt_d   = div_cnt;
      bp_skip_d   = bp_skip;
      cpu_reset_d = cpu_reset;
      reason_d    = halt_reason;
      count_d     = cycle_count;
      unique case (cur_st)
         ST_RST: begin
            if (rst_done) begin
               nxt_st      = ST_IDLE;
               cpu_reset_d = 1'b0;
            end else begin
               rst_cnt_d = rst_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            div_cnt_d = '0;
            if (!halt_req && (run_req || step_req)) begin
               nxt_st    = run_req ? ST_RUN : ST_STEP;
               reason_d  = HR_NONE;
               bp_skip_d = 1'b1;
            end
         end
         ST_RUN, ST_STEP: begin
            if (halt_req) begin
               nxt_st    = ST_IDLE;
               div_cnt_d = '0;
               reason_d  = HR_REQ;
            end else if (!issue) begin
               div_cnt_d = div_cnt + 1'b1;
            end else begin
               div_cnt_d = '0;
               if (halt_instr) begin
                  nxt_st   = ST_IDLE;
                  reason_d = HR_INSTR;
               end else if (bp_hit) begin
                  nxt_st   = ST_IDLE;
                  reason_d = HR_BP;
               end else begin
                  count_d   = cycle_count + 1'b1;
                  bp_skip_d = 1'b0;
                  if (cur_st == ST_STEP) begin
                     nxt_st   = ST_IDLE;
                     reason_d = HR_NONE;
                  end
               end
            end
         end
         default: begin
            nxt_st = ST_RST;
         end
      endcase
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Run-control sequencer for the single-cycle CPU.
- Runs on the fast system clock and produces a one-cycle commit enable (cpu_ce) every DIV fast cycles. This replaces the free-running divided slow clock.
- Also holds the datapath in reset after power-up and provides run / halt / single-step control.
- Stops on a PC breakpoint or a decoded halt instruction; keeps a committed-instruction counter for debug and bench use.

Parameters:
- DIV, 22, fast-clock cycles per CPU instruction commit (≥2).
- RESET_CYCLES, 4, cycles cpu_reset is held after reset deasserts (≥1).
- PC_W, 32, width of pc and bp_addr.
- CNT_W, 32, width of cycle_count.

Ports:
- CLK  in  1  fast system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run_req  in  1  level; honoured in IDLE only.
- halt_req  in  1  level; stops RUN/STEP.
- step_req  in  1  level; honoured in IDLE only.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current CPU PC (instruction about to commit).
- halt_instr  in  1  decoder flags the current instruction as halt.
- cpu_ce  out  1  commit enable to CPU state elements (combinational, one cycle wide).
- cpu_reset  out  1  active-high reset to datapath (registered).
- state  out  2  0=RST, 1=IDLE, 2=RUN, 3=STEP.
- halt_reason  out  2  0=none/step done, 1=halt_req, 2=breakpoint, 3=halt_instr.
- cycle_count  out  CNT_W  number of cpu_ce pulses since reset.

Behaviour:
- Async reset (any time, including mid-run):
  - state=RST, cpu_reset=1, rst_cnt=0, div_cnt=0, cycle_count=0, halt_reason=0, bp_skip=0.
  - cpu_ce=0 immediately.
- RST: rst_cnt increments each cycle. When rst_cnt==RESET_CYCLES-1, the next edge sets cpu_reset=0 and state=IDLE. All requests are ignored in RST.
- IDLE: div_cnt held at 0, cpu_ce=0.
  - run_req → RUN on next edge; step_req → STEP. run_req wins if both are asserted.
  - halt_req asserted in the same cycle blocks the transition.
  - On leaving IDLE: halt_reason←0, bp_skip←1.
- RUN/STEP divider: div_cnt counts 0..DIV-1 and wraps to 0. The issue point is the cycle with div_cnt==DIV-1.
- Stop conditions in RUN/STEP, evaluated every cycle; the first matching entry applies:
  - halt_req (any cycle): cpu_ce=0; next edge state=IDLE, div_cnt=0, halt_reason=1.
  - At issue point, halt_instr=1: cpu_ce=0; → IDLE, halt_reason=3. The halt instruction is not committed; PC stays on it.
  - At issue point, bp_en && pc==bp_addr && !bp_skip: cpu_ce=0; → IDLE, halt_reason=2.
  - Otherwise at issue point: cpu_ce=1, cycle_count+=1 (wraps mod 2^CNT_W), bp_skip←0.
- STEP: after its single cpu_ce pulse, next edge → IDLE with halt_reason=0.
- Latency: request sampled at edge t → state changes at t+1 → first cpu_ce in cycle t+DIV (div_cnt 0..DIV-1 starting at t+1).
- Resume: bp_skip lets run or step from a breakpoint PC commit that instruction once. The breakpoint re-arms after the first commit.
- cpu_ce is never asserted outside RUN/STEP, nor while cpu_reset=1.

Test Plan (DIV=4, RESET_CYCLES=4):
1. Reset release → cpu_reset=1 for exactly 4 cycles, then state=1. run_req held during RST has no effect.
2. Reset release, run_req pulse, bp_en=0, halt_instr=0 for 40 cycles → cpu_ce pulses every 4 cycles, first at 4 cycles after RUN entry. cycle_count=10 at 40 cycles of RUN.
3. From IDLE, step_req 1 cycle → exactly one cpu_ce, state back to 1, halt_reason=0, cycle_count+1.
4. bp_en=1, bp_addr=0x0000000C, pc=0x0000000C at the third issue point → no cpu_ce, state=1, halt_reason=2. Then run_req → first issue at 0x0C commits. A later revisit of 0x0C stops again.
5. RUN, halt_instr=1 at an issue point → cpu_ce=0, halt_reason=3, cycle_count unchanged. Separately, halt_req at div_cnt=1 → IDLE next edge, halt_reason=1, div_cnt=0.
6. Assert reset mid-RUN at div_cnt=2 → cpu_ce drops immediately, cpu_reset=1, cycle_count=0, state=0. Then 4-cycle reset hold repeats.
